cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter and broadcaster for the Tomasulo core. Takes completed results from `FU_NUM` functional units (ALU, load, store, branch reservation stations) and grants up to `CDB_LANES` of them per cycle, using a rotating fair order. Winners are broadcast on registered CDB lanes consumed by the reorder buffer and all reservation stations. This generalises the fixed single-pass CDB data controller with:
- multi-lane issue;
- starvation-free round-robin;
- an explicit ack handshake;
- flush;
- an optional RB-indexed output view.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_rr_multi_grant.sv | 38 +++
 rtl/cdb_arbiter.sv | 132 +++++++++++++
 tb/tb_cdb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared core parameters for the common-data-bus arbiter: bus widths, RB geometry,
// FU index map and the lane / indexed-view defaults.
package cdb_arbiter_pkg;

    localparam int unsigned WORD_SIZE   = 32;
    localparam int unsigned RB_INDEX    = 4;
    localparam int unsigned RB_SIZE     = 16;
    localparam int unsigned FU_NUM      = 8;
    localparam int unsigned CDB_LANES   = 2;
    localparam bit          INDEXED_OUT = 1'b1;

    // Requester slot of each functional unit on the arbiter inputs.
    typedef enum logic [2:0] {
        FU_ALU0   = 3'd0,
        FU_ALU1   = 3'd1,
        FU_ALU2   = 3'd2,
        FU_ALU3   = 3'd3,
        FU_LOAD0  = 3'd4,
        FU_LOAD1  = 3'd5,
        FU_STORE  = 3'd6,
        FU_BRANCH = 3'd7
    } fu_id_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Combinational N-of-M rotating priority selector: scans requests from the pointer,
// wrapping, and hands the first N requesters to lanes 0..N-1 in scan order.
module rr_multi_grant
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned M  = 8,
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(M)
) (
    input  logic [M-1:0]    i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [M-1:0]    o_grant,
    output logic [N*IW-1:0] o_lane_idx,
    output logic [N-1:0]    o_lane_vld,
    output logic [IW-1:0]   o_last_idx
);

    always_comb begin
        int unsigned cnt;
        int unsigned idx;
        o_grant    = '0;
        o_lane_idx = '0;
        o_lane_vld = '0;
        o_last_idx = '0;
        cnt        = 0;
        for (int unsigned k = 0; k < M; k++) begin
            idx = (32'(i_ptr) + k) % M;
            if (i_req[idx] && (cnt < N)) begin
                o_grant[idx]                = 1'b1;
                o_lane_idx[cnt*IW +: IW]    = idx[IW-1:0];
                o_lane_vld[cnt]             = 1'b1;
                o_last_idx                  = idx[IW-1:0];
                cnt                         = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-lane CDB arbiter: round-robin grants up to CDB_LANES finished FU results per
// cycle, registers them onto the broadcast lanes and optionally fans them out by RB tag.
module cdb_arbiter
    import cdb_arbiter_pkg::idx_w;
#(
    parameter int unsigned WORD_SIZE   = cdb_arbiter_pkg::WORD_SIZE,
    parameter int unsigned RB_INDEX    = cdb_arbiter_pkg::RB_INDEX,
    parameter int unsigned RB_SIZE     = cdb_arbiter_pkg::RB_SIZE,
    parameter int unsigned FU_NUM      = cdb_arbiter_pkg::FU_NUM,
    parameter int unsigned CDB_LANES   = cdb_arbiter_pkg::CDB_LANES,
    parameter bit          INDEXED_OUT = cdb_arbiter_pkg::INDEXED_OUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [FU_NUM-1:0]              fu_valid,
    input  logic [FU_NUM*WORD_SIZE-1:0]    fu_data,
    input  logic [FU_NUM*WORD_SIZE-1:0]    fu_addr,
    input  logic [FU_NUM*RB_INDEX-1:0]     fu_rb_index,
    output logic [FU_NUM-1:0]              fu_ack,
    output logic [CDB_LANES-1:0]           cdb_valid,
    output logic [CDB_LANES*WORD_SIZE-1:0] cdb_data,
    output logic [CDB_LANES*WORD_SIZE-1:0] cdb_addr,
    output logic [CDB_LANES*RB_INDEX-1:0]  cdb_rb_index,
    output logic [RB_SIZE-1:0]             rb_valid,
    output logic [RB_SIZE*WORD_SIZE-1:0]   rb_data,
    output logic [RB_SIZE*WORD_SIZE-1:0]   rb_addr
);

    localparam int unsigned IW = idx_w(FU_NUM);

    logic [IW-1:0]                  r_rr_ptr;
    logic [CDB_LANES-1:0]           r_cdb_valid;
    logic [CDB_LANES*WORD_SIZE-1:0] r_cdb_data;
    logic [CDB_LANES*WORD_SIZE-1:0] r_cdb_addr;
    logic [CDB_LANES*RB_INDEX-1:0]  r_cdb_tag;

    logic [FU_NUM-1:0]              w_req;
    logic [FU_NUM-1:0]              w_grant;
    logic [CDB_LANES*IW-1:0]        w_lane_idx;
    logic [CDB_LANES-1:0]           w_lane_vld;
    logic [IW-1:0]                  w_last_idx;
    logic [IW-1:0]                  w_ptr_nxt;
    logic [CDB_LANES*WORD_SIZE-1:0] w_nxt_data;
    logic [CDB_LANES*WORD_SIZE-1:0] w_nxt_addr;
    logic [CDB_LANES*RB_INDEX-1:0]  w_nxt_tag;

    // Masking requests keeps fu_ack independent of payloads and silent under reset/flush.
    assign w_req  = (reset || flush) ? '0 : fu_valid;
    assign fu_ack = w_grant;

    rr_multi_grant #(
        .M  (FU_NUM),
        .N  (CDB_LANES),
        .IW (IW)
    ) u_sel (
        .i_req      (w_req),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_lane_idx (w_lane_idx),
        .o_lane_vld (w_lane_vld),
        .o_last_idx (w_last_idx)
    );

    assign w_ptr_nxt = (w_last_idx == IW'(FU_NUM - 1)) ? '0 : w_last_idx + IW'(1);

    always_comb begin
        logic [IW-1:0] sel;
        w_nxt_data = '0;
        w_nxt_addr = '0;
        w_nxt_tag  = '0;
        for (int unsigned l = 0; l < CDB_LANES; l++) begin
            sel = w_lane_idx[l*IW +: IW];
            if (w_lane_vld[l]) begin
                w_nxt_data[l*WORD_SIZE +: WORD_SIZE] = fu_data[sel*WORD_SIZE +: WORD_SIZE];
                w_nxt_addr[l*WORD_SIZE +: WORD_SIZE] = fu_addr[sel*WORD_SIZE +: WORD_SIZE];
                w_nxt_tag[l*RB_INDEX +: RB_INDEX]    = fu_rb_index[sel*RB_INDEX +: RB_INDEX];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (|w_grant) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_cdb_valid <= '0;
            r_cdb_data  <= '0;
            r_cdb_addr  <= '0;
            r_cdb_tag   <= '0;
        end else begin
            r_cdb_valid <= w_lane_vld;
            r_cdb_data  <= w_nxt_data;
            r_cdb_addr  <= w_nxt_addr;
            r_cdb_tag   <= w_nxt_tag;
        end
    end

    assign cdb_valid    = r_cdb_valid;
    assign cdb_data     = r_cdb_data;
    assign cdb_addr     = r_cdb_addr;
    assign cdb_rb_index = r_cdb_tag;

    generate
        if (INDEXED_OUT) begin : g_rb_view
            always_comb begin
                logic [RB_INDEX-1:0] tag;
                rb_valid = '0;
                rb_data  = '0;
                rb_addr  = '0;
                for (int unsigned l = 0; l < CDB_LANES; l++) begin
                    tag = r_cdb_tag[l*RB_INDEX +: RB_INDEX];
                    if (r_cdb_valid[l]) begin
                        rb_valid[tag]                        = 1'b1;
                        rb_data[tag*WORD_SIZE +: WORD_SIZE]  = r_cdb_data[l*WORD_SIZE +: WORD_SIZE];
                        rb_addr[tag*WORD_SIZE +: WORD_SIZE]  = r_cdb_addr[l*WORD_SIZE +: WORD_SIZE];
                    end
                end
            end
        end else begin : g_rb_off
            assign rb_valid = '0;
            assign rb_data  = '0;
            assign rb_addr  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 2-lane indexed build and a 1-lane non-indexed build share
// stimulus and are checked against a queue-based rotating-order reference model.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic [7:0]   fu_valid;
    logic [31:0]  d [8];
    logic [31:0]  a [8];
    logic [3:0]   t [8];
    logic [255:0] fu_data;
    logic [255:0] fu_addr;
    logic [31:0]  fu_rb_index;

    logic [7:0]   fu_ack_a;
    logic [1:0]   cdb_valid_a;
    logic [63:0]  cdb_data_a, cdb_addr_a;
    logic [7:0]   cdb_rb_index_a;
    logic [15:0]  rb_valid_a;
    logic [511:0] rb_data_a, rb_addr_a;

    logic [7:0]   fu_ack_b;
    logic [0:0]   cdb_valid_b;
    logic [31:0]  cdb_data_b, cdb_addr_b;
    logic [3:0]   cdb_rb_index_b;
    logic [15:0]  rb_valid_b;
    logic [511:0] rb_data_b, rb_addr_b;

    int unsigned  n_asserts = 0;
    int unsigned  n_fail    = 0;
    int unsigned  m_ptr_a   = 0;
    int unsigned  m_ptr_b   = 0;
    logic [7:0]   m_last_ga = '0;

    always #5 clk = ~clk;

    always_comb begin
        fu_data     = '0;
        fu_addr     = '0;
        fu_rb_index = '0;
        for (int i = 0; i < 8; i++) begin
            fu_data[i*32 +: 32]    = d[i];
            fu_addr[i*32 +: 32]    = a[i];
            fu_rb_index[i*4 +: 4]  = t[i];
        end
    end

    cdb_arbiter #(
        .WORD_SIZE(32), .RB_INDEX(4), .RB_SIZE(16), .FU_NUM(8),
        .CDB_LANES(2), .INDEXED_OUT(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_data(fu_data), .fu_addr(fu_addr), .fu_rb_index(fu_rb_index),
        .fu_ack(fu_ack_a), .cdb_valid(cdb_valid_a), .cdb_data(cdb_data_a), .cdb_addr(cdb_addr_a),
        .cdb_rb_index(cdb_rb_index_a), .rb_valid(rb_valid_a), .rb_data(rb_data_a), .rb_addr(rb_addr_a)
    );

    cdb_arbiter #(
        .WORD_SIZE(32), .RB_INDEX(4), .RB_SIZE(16), .FU_NUM(8),
        .CDB_LANES(1), .INDEXED_OUT(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_data(fu_data), .fu_addr(fu_addr), .fu_rb_index(fu_rb_index),
        .fu_ack(fu_ack_b), .cdb_valid(cdb_valid_b), .cdb_data(cdb_data_b), .cdb_addr(cdb_addr_b),
        .cdb_rb_index(cdb_rb_index_b), .rb_valid(rb_valid_b), .rb_data(rb_data_b), .rb_addr(rb_addr_b)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: list FUs in rotating order from ptr, keep the requesters, take the first `lanes`.
    function automatic void arb(input int unsigned ptr, input int unsigned lanes, input logic [7:0] req,
                                output logic [7:0] g, output int unsigned win[2],
                                output int unsigned n, output int unsigned nptr);
        int unsigned order[$];
        int unsigned cand[$];
        int unsigned sz;
        g      = '0;
        win[0] = 0;
        win[1] = 0;
        for (int unsigned k = 0; k < 8; k++) order.push_back((ptr + k) % 8);
        cand = order.find(x) with (req[x] == 1'b1);
        sz   = cand.size();
        n    = (sz < lanes) ? sz : lanes;
        nptr = (n == 0) ? ptr : (cand[n-1] + 1) % 8;
        for (int unsigned j = 0; j < n; j++) begin
            g[cand[j]] = 1'b1;
            win[j]     = cand[j];
        end
    endfunction

    task automatic ack_is(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, 512'(fu_ack_a), 512'(exp));
    endtask

    task automatic step(input string tag);
        logic [7:0]   ga, gb;
        int unsigned  wa[2], wb[2];
        int unsigned  na, nb, pa, pb;
        logic [1:0]   ev_a;
        logic [63:0]  ed_a, ea_a;
        logic [7:0]   et_a;
        logic [15:0]  erv;
        logic [511:0] erd, era;
        logic         ev_b;
        logic [31:0]  ed_b, ea_b;
        logic [3:0]   et_b;
        #1;
        arb(m_ptr_a, 2, fu_valid, ga, wa, na, pa);
        arb(m_ptr_b, 1, fu_valid, gb, wb, nb, pb);
        if (reset || flush) begin
            ga = '0; gb = '0; na = 0; nb = 0; pa = m_ptr_a; pb = m_ptr_b;
        end
        if (reset) begin
            pa = 0; pb = 0;
        end
        m_last_ga = ga;
        chk({tag, ".ack_a"}, 512'(fu_ack_a), 512'(ga));
        chk({tag, ".ack_b"}, 512'(fu_ack_b), 512'(gb));
        ev_a = '0; ed_a = '0; ea_a = '0; et_a = '0; erv = '0; erd = '0; era = '0;
        for (int unsigned l = 0; l < na; l++) begin
            ev_a[l]                = 1'b1;
            ed_a[l*32 +: 32]       = d[wa[l]];
            ea_a[l*32 +: 32]       = a[wa[l]];
            et_a[l*4 +: 4]         = t[wa[l]];
            erv[t[wa[l]]]          = 1'b1;
            erd[t[wa[l]]*32 +: 32] = d[wa[l]];
            era[t[wa[l]]*32 +: 32] = a[wa[l]];
        end
        ev_b = (nb == 1);
        ed_b = ev_b ? d[wb[0]] : '0;
        ea_b = ev_b ? a[wb[0]] : '0;
        et_b = ev_b ? t[wb[0]] : '0;
        @(posedge clk);
        #1;
        m_ptr_a = pa;
        m_ptr_b = pb;
        chk({tag, ".valid_a"}, 512'(cdb_valid_a), 512'(ev_a));
        chk({tag, ".data_a"},  512'(cdb_data_a),  512'(ed_a));
        chk({tag, ".addr_a"},  512'(cdb_addr_a),  512'(ea_a));
        chk({tag, ".tag_a"},   512'(cdb_rb_index_a), 512'(et_a));
        chk({tag, ".rbv_a"},   512'(rb_valid_a),  512'(erv));
        chk({tag, ".rbd_a"},   rb_data_a, erd);
        chk({tag, ".rba_a"},   rb_addr_a, era);
        chk({tag, ".ptr_a"},   512'(dut_a.r_rr_ptr), 512'(pa));
        chk({tag, ".dup_tag"}, 512'(cdb_valid_a[0] && cdb_valid_a[1] &&
                                    (cdb_rb_index_a[3:0] == cdb_rb_index_a[7:4])), 512'(0));
        chk({tag, ".valid_b"}, 512'(cdb_valid_b), 512'(ev_b));
        chk({tag, ".data_b"},  512'(cdb_data_b),  512'(ed_b));
        chk({tag, ".addr_b"},  512'(cdb_addr_b),  512'(ea_b));
        chk({tag, ".tag_b"},   512'(cdb_rb_index_b), 512'(et_b));
        chk({tag, ".ptr_b"},   512'(dut_b.r_rr_ptr), 512'(pb));
        chk({tag, ".rbv_b"},   512'(rb_valid_b), 512'(0));
        chk({tag, ".rbd_b"},   rb_data_b, 512'(0));
        chk({tag, ".rba_b"},   rb_addr_b, 512'(0));
    endtask

    initial begin
        logic [31:0] s1_word;
        int unsigned r;
        reset    = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 32'h1000 + 32'(i);
            a[i] = 32'h2000 + 32'(i);
            t[i] = 4'(2 * i + 1);
        end
        step("reset");

        // single request from FU0 with tag 3
        reset    = 1'b0;
        d[0]     = 32'hA5;
        t[0]     = 4'd3;
        fu_valid = 8'b0000_0001;
        ack_is("s1.ack", 8'h01);
        step("s1");
        s1_word = rb_data_a[3*32 +: 32];
        chk("s1.cdb_valid", 512'(cdb_valid_a), 512'(2'b01));
        chk("s1.cdb_data0", 512'(cdb_data_a[31:0]), 512'(32'hA5));
        chk("s1.rb_valid",  512'(rb_valid_a), 512'(16'h0008));
        chk("s1.rb_data3",  512'(s1_word), 512'(32'hA5));
        chk("s1.ptr",       512'(dut_a.r_rr_ptr), 512'(1));
        chk("s1.cdb_data_b", 512'(cdb_data_b), 512'(32'hA5));
        fu_valid = '0;
        t[0]     = 4'd0;
        step("s1_idle");

        // all FUs held until acked, starting from pointer 0
        reset = 1'b1;
        step("s2_reset");
        reset    = 1'b0;
        fu_valid = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            ack_is($sformatf("s2.pair%0d", i), 8'(8'h03 << (2 * i)));
            step($sformatf("s2_%0d", i));
            fu_valid = fu_valid & ~m_last_ga;
        end
        chk("s2.drained", 512'(fu_valid), 512'(0));
        step("s2_idle");

        // wrap-around from pointer 6
        fu_valid = 8'h20;
        step("s3_setptr");
        chk("s3.ptr6", 512'(dut_a.r_rr_ptr), 512'(6));
        fu_valid = 8'b1100_0010;
        ack_is("s3.ack67", 8'hC0);
        step("s3_wrap");
        chk("s3.ptr0", 512'(dut_a.r_rr_ptr), 512'(0));
        fu_valid = 8'h02;
        ack_is("s3.ack1", 8'h02);
        step("s3_fu1");

        // flush with a lane still valid from the previous grant
        fu_valid = 8'h04;
        flush    = 1'b1;
        ack_is("s4.flush_ack", 8'h00);
        step("s4_flush");
        chk("s4.cleared", 512'(cdb_valid_a), 512'(0));
        flush = 1'b0;
        ack_is("s4.ack2", 8'h04);
        step("s4_after");

        // reset (with flush) while two lanes are valid
        fu_valid = 8'h30;
        step("s5_fill");
        chk("s5.two_lanes", 512'(cdb_valid_a), 512'(2'b11));
        reset    = 1'b1;
        flush    = 1'b1;
        fu_valid = 8'h0F;
        ack_is("s5.ack", 8'h00);
        step("s5_reset");
        chk("s5.ptr", 512'(dut_a.r_rr_ptr), 512'(0));
        reset    = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;

        // randomized traffic: requests held until acked, occasional flush/reset
        for (int unsigned c = 0; c < 400; c++) begin
            r     = $urandom_range(0, 99);
            reset = (r < 2);
            flush = (r >= 2) && (r < 8);
            step("rnd");
            for (int i = 0; i < 8; i++) begin
                if (reset || m_last_ga[i]) begin
                    fu_valid[i] = 1'b0;
                end else if (!fu_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    fu_valid[i] = 1'b1;
                    d[i]        = $urandom;
                    a[i]        = $urandom;
                    t[i]        = 4'(2 * i + $urandom_range(0, 1));
                end
            end
        end
        reset    = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        step("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
